// File: rtl/vbs_defs.sv
// vbs_defs: line/timing constants shared by the sync generator and the pixel fetcher
package vbs_defs;
  localparam int LINE_COUNT = 313;
  localparam int CLOCKS_PER_LINE = 512;
  localparam int BYTES_PER_LINE_DEF = 32;
  localparam int LEAD_DEF = 16;
  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_DRAIN} fetch_state_t;
  function automatic int byte_addr(int base, int line, int bpl, int idx);
    return base + line * bpl + idx;
  endfunction
endpackage

// File: rtl/byte_fifo2.sv
// byte_fifo2: 2-entry byte FIFO; pop on empty is ignored so a late push still lands
module byte_fifo2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  logic [7:0] mem [2];
  logic       wp, rp;
  logic [1:0] cnt;
  logic       do_push, do_pop;
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign dout = mem[rp];
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  // Storage and pointers; flush drops everything including a same-cycle push
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
    end else if (flush) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      wp <= wp ^ do_push;
      rp <= rp ^ do_pop;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
endmodule

// File: rtl/vbs_pixel_fetcher.sv
// vbs_pixel_fetcher: fetches bitmap bytes over req/ack and serialises them MSB-first into a fixed-timing pixel stream
module vbs_pixel_fetcher
  import vbs_defs::*;
#(
  parameter int BYTES_PER_LINE = BYTES_PER_LINE_DEF,
  parameter int ADDR_WIDTH = 13,
  parameter int BASE_ADDR = 0,
  parameter int LEAD = LEAD_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_start,
  input  logic                  line_active,
  input  logic [7:0]            line_number,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_data,
  output logic                  pixel,
  output logic                  pixel_valid,
  output logic                  underrun
);
  localparam int LW = $clog2(LEAD);
  localparam int BW = $clog2(BYTES_PER_LINE);
  localparam int FW = $clog2(BYTES_PER_LINE + 1);
  fetch_state_t          state, state_nxt;
  logic [7:0]            line_q, shreg, fifo_dout;
  logic [FW-1:0]         fetch_idx;
  logic [LW-1:0]         lead_cnt;
  logic [2:0]            bit_cnt;
  logic [BW-1:0]         byte_cnt;
  logic                  discard;
  logic [ADDR_WIDTH-1:0] hold_addr, calc_addr;
  logic                  retrig, lead_done, last, fetch_req, push, pop, flush, fifo_full, fifo_empty;
  byte_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (mem_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign pixel = shreg[7];
  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nxt;
  // Next state: any line_start restarts (or drops) the line; otherwise LEAD -> SHIFT -> DRAIN -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_LEAD:  state_nxt = lead_done ? S_SHIFT : S_LEAD;
      S_SHIFT: state_nxt = last ? S_DRAIN : S_SHIFT;
      S_DRAIN: state_nxt = (discard && !mem_ack) ? S_DRAIN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (line_start) state_nxt = line_active ? S_LEAD : S_IDLE;
  end
  // Outputs and strobes; an abandoned request keeps mem_req and its address until the ack retires it
  always_comb begin
    retrig = line_start && state != S_IDLE;
    lead_done = state == S_LEAD && lead_cnt == LW'(LEAD - 2);
    last = state == S_SHIFT && bit_cnt == 3'd7 && byte_cnt == BW'(BYTES_PER_LINE - 1);
    fetch_req = (state == S_LEAD || state == S_SHIFT) && !discard && fetch_idx < FW'(BYTES_PER_LINE) && !fifo_full;
    mem_req = fetch_req || discard;
    push = fetch_req && mem_ack;
    pop = !line_start && (lead_done || (state == S_SHIFT && bit_cnt == 3'd7 && !last));
    underrun = pop && fifo_empty;
    flush = line_start || state == S_DRAIN;
    calc_addr = ADDR_WIDTH'(byte_addr(BASE_ADDR, int'(line_q), BYTES_PER_LINE, int'(fetch_idx)));
    mem_addr = discard ? hold_addr : calc_addr;
  end
  // Line context, counters, shifter and the outstanding-request tracker
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      line_q <= '0;
      fetch_idx <= '0;
      lead_cnt <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      shreg <= '0;
      pixel_valid <= 1'b0;
      discard <= 1'b0;
      hold_addr <= '0;
    end else begin
      line_q <= (line_start && line_active) ? line_number : line_q;
      fetch_idx <= line_start ? '0 : fetch_idx + FW'(push);
      lead_cnt <= (line_start || state != S_LEAD) ? '0 : lead_cnt + LW'(1);
      bit_cnt <= (state == S_SHIFT && !line_start) ? bit_cnt + 3'd1 : '0;
      byte_cnt <= (state == S_SHIFT && !line_start) ? byte_cnt + BW'(bit_cnt == 3'd7) : '0;
      shreg <= (line_start || last) ? '0 : pop ? (fifo_empty ? '0 : fifo_dout) : state == S_SHIFT ? shreg << 1 : shreg;
      pixel_valid <= (line_start || last) ? 1'b0 : lead_done ? 1'b1 : pixel_valid;
      discard <= discard ? !mem_ack : (retrig || last) && fetch_req && !mem_ack;
      hold_addr <= mem_addr;
    end
endmodule

// File: tb/tb_vbs_pixel_fetcher.sv
// tb_vbs_pixel_fetcher: directed vector table plus retrigger/reset sequences against a req/ack RAM model
module tb_vbs_pixel_fetcher;
  logic        clk = 1'b0, reset = 1'b1, line_start = 1'b0, line_active = 1'b0;
  logic [7:0]  line_number = '0;
  logic        mem_req, mem_ack = 1'b0;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic        pixel, pixel_valid, underrun;
  logic [7:0]  ram [8192];
  int lat = 0, stall_addr = -1, stall_lat = 0, wcnt = 0;
  int n_checks = 0, n_err = 0;
  int valid_cnt, underruns, ur_cycle, first_valid, first_addr, req_cycles, outside, end_busy;
  int ign_lo = -1, ign_hi = -1;
  logic [255:0] stream;
  logic pix16, pix31, k1_req, k1_pv;
  int k1_addr;

  typedef struct {
    int lat; int stall_addr; int stall_lat; int line; int active;
    int first_addr; int valid; int underruns; int ur_cycle; int first_valid; int slip; int p16; int p31;
  } vec_t;
  vec_t vecs [6];

  vbs_pixel_fetcher dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_active(line_active),
    .line_number(line_number), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .pixel(pixel), .pixel_valid(pixel_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // RAM model: acks after lat waiting clocks (stall_lat for stall_addr), data valid with the ack
  always @(negedge clk) begin
    if (mem_req && wcnt >= ((int'(mem_addr) == stall_addr) ? stall_lat : lat)) begin
      mem_ack = 1'b1;
      mem_data = ram[mem_addr];
      wcnt = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt = mem_req ? wcnt + 1 : 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_stream(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_stream(input int base, input int slip);
    logic [255:0] s;
    logic [7:0] b;
    for (int j = 0; j < 32; j++) begin
      b = (slip >= 0 && j == slip) ? 8'h00 : (slip >= 0 && j > slip) ? ram[base + j - 1] : ram[base + j];
      s[255 - 8 * j -: 8] = b;
    end
    return s;
  endfunction

  task automatic start_line(input int line, input int active);
    line_number = 8'(line);
    line_active = active[0];
    line_start = 1'b1;
  endtask

  task automatic capture(input int n);
    valid_cnt = 0; underruns = 0; ur_cycle = -1; first_valid = -1; first_addr = -1;
    req_cycles = 0; outside = 0; end_busy = 0; stream = '0; pix16 = 0; pix31 = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        line_start = 1'b0;
        k1_req = mem_req;
        k1_pv = pixel_valid;
        k1_addr = int'(mem_addr);
      end
      if (pixel_valid) begin
        if (valid_cnt == 0) first_valid = k;
        if (valid_cnt < 256) stream[255 - valid_cnt] = pixel;
        valid_cnt++;
      end
      if (pixel && !pixel_valid) outside++;
      if (underrun) begin
        underruns++;
        if (ur_cycle < 0) ur_cycle = k;
      end
      if (mem_req) req_cycles++;
      if (first_addr < 0 && mem_req && (int'(mem_addr) < ign_lo || int'(mem_addr) > ign_hi)) first_addr = int'(mem_addr);
      if (k == 16) pix16 = pixel;
      if (k == 31) pix31 = pixel;
      if (k == n) end_busy = int'(mem_req | pixel_valid);
    end
  endtask

  initial begin
    int found, act;
    logic prev;
    for (int i = 0; i < 8192; i++) ram[i] = 8'(i * 37 + 11);
    ram[96] = 8'h80;
    ram[97] = 8'h01;
    vecs[0] = '{0, -1, 0, 3, 1, 96, 256, 0, -1, 16, -1, 1, 1};
    vecs[1] = '{3, -1, 0, 3, 1, 96, 256, 0, -1, 16, -1, 1, 1};
    vecs[2] = '{0, 101, 20, 3, 1, 96, 256, 1, 55, 16, 5, 1, 1};
    vecs[3] = '{0, -1, 0, 9, 0, -1, 0, 0, -1, -1, -1, 0, 0};
    vecs[4] = '{1, -1, 0, 255, 1, 8160, 256, 0, -1, 16, -1, -1, -1};
    vecs[5] = '{0, -1, 0, 0, 1, 0, 256, 0, -1, 16, -1, -1, -1};
    repeat (3) @(negedge clk);
    check("reset mem_req", int'(mem_req), 0);
    check("reset mem_addr", int'(mem_addr), 0);
    check("reset pixel", int'(pixel), 0);
    check("reset pixel_valid", int'(pixel_valid), 0);
    check("reset underrun", int'(underrun), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      lat = vecs[i].lat;
      stall_addr = vecs[i].stall_addr;
      stall_lat = vecs[i].stall_lat;
      start_line(vecs[i].line, vecs[i].active);
      capture(320);
      check($sformatf("v%0d first_addr", i), first_addr, vecs[i].first_addr);
      check($sformatf("v%0d valid_cnt", i), valid_cnt, vecs[i].valid);
      check($sformatf("v%0d first_valid", i), first_valid, vecs[i].first_valid);
      check($sformatf("v%0d underruns", i), underruns, vecs[i].underruns);
      check($sformatf("v%0d underrun_cycle", i), ur_cycle, vecs[i].ur_cycle);
      check($sformatf("v%0d pixel_outside", i), outside, 0);
      check($sformatf("v%0d idle_at_end", i), end_busy, 0);
      if (vecs[i].p16 >= 0) check($sformatf("v%0d pixel@16", i), int'(pix16), vecs[i].p16);
      if (vecs[i].p31 >= 0) check($sformatf("v%0d pixel@31", i), int'(pix31), vecs[i].p31);
      if (vecs[i].active != 0) check_stream($sformatf("v%0d stream", i), stream, exp_stream(vecs[i].line * 32, vecs[i].slip));
      else check($sformatf("v%0d req_cycles", i), req_cycles, 0);
    end

    // retrigger mid-SHIFT just as a new request is raised (latency 4 keeps it outstanding)
    lat = 4; stall_addr = -1;
    start_line(3, 1);
    @(negedge clk);
    line_start = 1'b0;
    found = 0;
    prev = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i >= 30 && mem_req && !prev && pixel_valid) begin
        found = 1;
        break;
      end
      prev = mem_req;
      @(negedge clk);
    end
    check("retrig reached", found, 1);
    ign_lo = 96; ign_hi = 127;
    start_line(7, 1);
    capture(320);
    check("retrig pixel_valid dropped", int'(k1_pv), 0);
    check("retrig req held", int'(k1_req), 1);
    check("retrig held addr in old line", int'(k1_addr >= 96 && k1_addr <= 127), 1);
    check("retrig new first_addr", first_addr, 224);
    check("retrig first_valid", first_valid, 16);
    check("retrig valid_cnt", valid_cnt, 256);
    check("retrig underruns", underruns, 0);
    check_stream("retrig stream", stream, exp_stream(224, -1));
    ign_lo = -1; ign_hi = -1;

    // asynchronous reset mid-line while a request is pending
    lat = 6;
    start_line(3, 1);
    @(negedge clk);
    line_start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (mem_req && pixel_valid) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst reached", found, 1);
    #1 reset = 1'b1;
    #1;
    check("rst async mem_req", int'(mem_req), 0);
    check("rst async pixel_valid", int'(pixel_valid), 0);
    check("rst async pixel", int'(pixel), 0);
    check("rst async underrun", int'(underrun), 0);
    check("rst async mem_addr", int'(mem_addr), 0);
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (40) begin
      @(negedge clk);
      act += int'(mem_req | pixel_valid | underrun | pixel);
    end
    check("rst quiet after release", act, 0);
    lat = 0;
    start_line(3, 1);
    capture(320);
    check("rst recover first_addr", first_addr, 96);
    check("rst recover valid_cnt", valid_cnt, 256);
    check_stream("rst recover stream", stream, exp_stream(96, -1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
